// File: rtl/fetch_stage.sv
// Instruction fetch: drives imem addresses, absorbs the 1-cycle imem latency, and buffers 2 entries for the decoder.
// Latency: 2 cycles from issue to head. Backpressure: stall holds the head; issue stops once the buffer is committed full.
module fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic [CW-1:0] count
);
  // Pointer wrap relies on DEPTH being a power of two.
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
endmodule

module fetch_stage #(
  parameter int                  PC_WIDTH = 12,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_q,
  input  logic                stall,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_target,
  output logic [31:0]         insn,
  output logic [4:0]          op,
  output logic [PC_WIDTH-1:0] insn_pc,
  output logic [PC_WIDTH-1:0] pc_plus1,
  output logic                insn_valid
);
  typedef struct packed {
    logic [31:0]         insn;
    logic [PC_WIDTH-1:0] pc;
  } entry_t;

  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] inflight_pc;
  logic                inflight;
  logic [1:0]          count;
  entry_t              head;
  entry_t              push_dat;
  logic                pop;
  logic                push;
  logic                issue;
  logic [2:0]          occ;

  assign insn_valid = (count != 2'd0);
  assign pop        = insn_valid & ~stall;
  assign push       = inflight & ~redirect;
  // Occupancy once this cycle's pop and pending return settle; a new issue needs a free slot.
  assign occ        = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
  assign issue      = ~redirect & (occ <= 3'd1);
  assign push_dat   = '{insn: imem_q, pc: inflight_pc};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      pc       <= redirect_target;
      inflight <= 1'b0;
    end else if (issue) begin
      pc          <= pc + 1'b1;
      inflight    <= 1'b1;
      inflight_pc <= pc;
    end else begin
      inflight <= 1'b0;
    end
  end

  fetch_fifo #(.W($bits(entry_t)), .DEPTH(2)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .flush    (redirect),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head),
    .count    (count)
  );

  assign imem_addr = pc;
  assign insn      = insn_valid ? head.insn : 32'h0;
  assign insn_pc   = insn_valid ? head.pc : '0;
  assign pc_plus1  = insn_pc + 1'b1;
  assign op        = insn[31:27];
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed timing table, async reset sequence, then random traffic against a queue model.
module tb_fetch_stage;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] imem_addr;
  logic [31:0] imem_q = 32'h0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [11:0] redirect_target = 12'h0;
  logic [31:0] insn;
  logic [4:0]  op;
  logic [11:0] insn_pc;
  logic [11:0] pc_plus1;
  logic        insn_valid;

  int total = 0;
  int bad   = 0;
  logic [31:0] salt = 32'h0;

  fetch_stage dut (
    .clock           (clock),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_q          (imem_q),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .insn            (insn),
    .op              (op),
    .insn_pc         (insn_pc),
    .pc_plus1        (pc_plus1),
    .insn_valid      (insn_valid)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_f(input logic [11:0] a);
    return (32'h1000_0000 + {20'h0, a}) ^ salt;
  endfunction

  always @(posedge clock) imem_q <= mem_f(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input bit ev, input logic [11:0] epc, input logic [11:0] eaddr);
    logic [31:0] ei;
    logic [11:0] ep;
    logic [11:0] ep1;
    ei  = ev ? mem_f(epc) : 32'h0;
    ep  = ev ? epc : 12'h0;
    ep1 = ep + 12'h1;
    chk({tag, " valid"},    32'(insn_valid), 32'(ev));
    chk({tag, " insn"},     insn, ei);
    chk({tag, " op"},       32'(op), 32'(ei[31:27]));
    chk({tag, " insn_pc"},  32'(insn_pc), 32'(ep));
    chk({tag, " pc_plus1"}, 32'(pc_plus1), 32'(ep1));
    chk({tag, " imem_addr"}, 32'(imem_addr), 32'(eaddr));
  endtask

  typedef struct {
    bit          st;
    bit          rd;
    logic [11:0] tg;
    bit          ev;
    logic [11:0] epc;
    logic [11:0] eaddr;
  } vec_t;

  vec_t tbl [32];

  function automatic void set_row(int i, bit st, bit rd, logic [11:0] tg, bit ev, logic [11:0] epc, logic [11:0] ea);
    tbl[i] = '{st: st, rd: rd, tg: tg, ev: ev, epc: epc, eaddr: ea};
  endfunction

  // Reference model state: queue of buffered pcs, pending request, next fetch pc.
  logic [11:0] mq [$];
  bit          mfl;
  logic [11:0] mfpc;
  logic [11:0] mpc;

  initial begin
    // Cycle index counts from reset release.
    set_row(0, 0, 0, 12'h0, 0, 12'h0, 12'h0);
    set_row(1, 0, 0, 12'h0, 0, 12'h0, 12'h1);
    for (int c = 2; c <= 4; c++) set_row(c, 0, 0, 12'h0, 1, 12'(c - 2), 12'(c));
    for (int c = 5; c <= 9; c++) set_row(c, 1, 0, 12'h0, 1, 12'h3, 12'h5);
    set_row(10, 0, 0, 12'h0,   1, 12'h3,   12'h5);
    set_row(11, 0, 0, 12'h0,   1, 12'h4,   12'h6);
    set_row(12, 0, 0, 12'h0,   1, 12'h5,   12'h7);
    set_row(13, 0, 0, 12'h0,   1, 12'h6,   12'h8);
    set_row(14, 1, 0, 12'h0,   1, 12'h7,   12'h9);
    set_row(15, 1, 1, 12'h040, 1, 12'h7,   12'h9);
    set_row(16, 0, 0, 12'h0,   0, 12'h0,   12'h040);
    set_row(17, 0, 0, 12'h0,   0, 12'h0,   12'h041);
    set_row(18, 0, 0, 12'h0,   1, 12'h040, 12'h042);
    set_row(19, 0, 0, 12'h0,   1, 12'h041, 12'h043);
    set_row(20, 0, 1, 12'h010, 1, 12'h042, 12'h044);
    set_row(21, 0, 1, 12'h020, 0, 12'h0,   12'h010);
    set_row(22, 0, 0, 12'h0,   0, 12'h0,   12'h020);
    set_row(23, 0, 0, 12'h0,   0, 12'h0,   12'h021);
    set_row(24, 0, 0, 12'h0,   1, 12'h020, 12'h022);
    set_row(25, 0, 0, 12'h0,   1, 12'h021, 12'h023);
    set_row(26, 0, 1, 12'hFFF, 1, 12'h022, 12'h024);
    set_row(27, 0, 0, 12'h0,   0, 12'h0,   12'hFFF);
    set_row(28, 0, 0, 12'h0,   0, 12'h0,   12'h000);
    set_row(29, 0, 0, 12'h0,   1, 12'hFFF, 12'h001);
    set_row(30, 0, 0, 12'h0,   1, 12'h000, 12'h002);
    set_row(31, 0, 0, 12'h0,   1, 12'h001, 12'h003);

    repeat (3) @(negedge clock);
    chk_out("reset", 0, 12'h0, 12'h0);
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      stall           = tbl[i].st;
      redirect        = tbl[i].rd;
      redirect_target = tbl[i].tg;
      chk_out($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].epc, tbl[i].eaddr);
      @(negedge clock);
    end
    redirect = 1'b0;
    redirect_target = 12'h0;

    // Fill the buffer, then hit reset between clock edges.
    stall = 1'b1;
    repeat (3) @(negedge clock);
    chk("full before arst", 32'(insn_valid), 32'h1);
    #2 reset = 1'b0;
    #1 chk_out("arst", 0, 12'h0, 12'h0);
    @(negedge clock);
    stall = 1'b0;
    reset = 1'b1;
    chk_out("restart0", 0, 12'h0, 12'h0);
    @(negedge clock);
    chk_out("restart1", 0, 12'h0, 12'h1);
    @(negedge clock);
    chk_out("restart2", 1, 12'h0, 12'h2);

    // Random traffic against the queue model, with a fresh memory image.
    @(negedge clock);
    reset = 1'b0;
    salt  = $urandom;
    @(negedge clock);
    reset = 1'b1;
    mq.delete();
    mfl  = 1'b0;
    mfpc = 12'h0;
    mpc  = 12'h0;
    for (int n = 0; n < 600; n++) begin
      bit          st;
      bit          rd;
      bit          ev;
      bit          pp;
      logic [11:0] tg;
      st = ($urandom_range(99) < 30);
      rd = ($urandom_range(99) < 6);
      tg = ($urandom_range(3) == 0) ? 12'hFFF : 12'($urandom);
      stall           = st;
      redirect        = rd;
      redirect_target = tg;
      ev = (mq.size() != 0);
      chk_out($sformatf("rnd%0d", n), ev, ev ? mq[0] : 12'h0, mpc);
      pp = ev && !st;
      if (rd) begin
        mq.delete();
        mfl = 1'b0;
        mpc = tg;
      end else begin
        if (pp) void'(mq.pop_front());
        if (mfl) mq.push_back(mfpc);
        mfl = (mq.size() <= 1);
        if (mfl) begin
          mfpc = mpc;
          mpc  = mpc + 12'h1;
        end
      end
      @(negedge clock);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
